mem_write_buffer: RTL and testbench
===================================

# mem_write_buffer

Posted-store buffer between the MIPS core's data-memory write port (memwrite / dataadr / writedata) and the data memory. Core stores are accepted in one cycle and queued in a small FIFO; the buffer drains them to memory under a ready handshake, so a slow memory stalls the core only when the queue is full. Loads that hit a queued store get the youngest matching data forwarded combinationally. The result is read-after-write correctness while stores are still pending.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- cpu_memwrite  input  1  core presents a word store this cycle
- cpu_adr  input  AW  store address, or load address when cpu_memread=1; full-width compare, word stores only
- cpu_writedata  input  DW  store data
- cpu_memread  input  1  core presents a load this cycle (forwarding lookup)
- cpu_stall  output  1  store not accepted; core must hold cpu_memwrite/cpu_adr/cpu_writedata
- fwd_hit  output  1  load address matches a queued entry
- fwd_data  output  DW  data of the youngest matching entry; 0 when fwd_hit=0
- mem_we  output  1  head entry valid and presented to memory
- mem_adr  output  AW  head entry address
- mem_wdata  output  DW  head entry data
- mem_ready  input  1  memory accepts the presented write this cycle
- empty  output  1  no queued entries; used by sync / test-end drain
- full  output  1  count == DEPTH
- count  output  $clog2(DEPTH)+1  queued entries

## Operation

- Storage: circular array of DEPTH {adr, data} entries, head and tail pointers of $clog2(DEPTH) bits, and a separate count register. Pointers wrap modulo DEPTH.
- Push: cpu_memwrite & ~full at the rising edge writes {cpu_adr, cpu_writedata} at tail, then tail+1.
- Pop: mem_we & mem_ready at the rising edge sets head+1.
- Simultaneous push and pop: both occur and count is unchanged. This is legal at any non-full count, including count==0 (pop is impossible there since mem_we=0).
- cpu_stall = cpu_memwrite & full. It never depends on mem_ready; no combinational path from mem_ready to cpu_stall. When full, the push is refused even if a pop occurs in the same cycle. The store is accepted on the next cycle.
- No coalescing: two stores to the same address occupy two entries and both drain in order.
- Drain order is strictly FIFO. mem_adr/mem_wdata come straight from the head entry registers. mem_we = ~empty.
- Forwarding:
  - fwd_hit = cpu_memread & (any valid entry has adr == cpu_adr).
  - fwd_data comes from the matching entry closest to tail (youngest).
  - An entry being popped in the current cycle still forwards.
  - A store presented in the same cycle is not visible to forwarding.
  - cpu_memread & cpu_memwrite together are not legal; when asserted together, push behaviour is unchanged and fwd outputs are don't-care.
- Reset: asynchronous clear of head, tail and count. Entry contents are not cleared. A store mid-drain is discarded; memory must tolerate a dropped mem_we.

## Timing

Reset values:
- mem_we=0, empty=1, full=0, count=0, cpu_stall=0, fwd_hit=0, fwd_data=0
- mem_adr/mem_wdata: don't-care while mem_we=0

Latency and handshake:
- Store accepted at edge N appears at mem_we/mem_adr/mem_wdata after edge N when the buffer was empty (1-cycle latency). Otherwise it appears after all older entries pop.
- Throughput: one pop per cycle with mem_ready held high. One push per cycle while not full.
- mem_we, once high, stays high with stable mem_adr/mem_wdata until the pop edge. Only reset may drop it.
- fwd_hit/fwd_data are combinational from cpu_adr, cpu_memread and registered state. They are valid in the same cycle.
- empty, full and count are registered-state-derived and change only at edges or reset.

## Test plan

- Reset mid-drain: 3 entries queued with mem_ready=0, assert reset for 2 ns -> count=0, mem_we=0, empty=1 immediately. After release, no stale write appears.
- Single store: store 21 to 0x18 with mem_ready=1 -> next cycle mem_we=1, mem_adr=0x18, mem_wdata=21; the following cycle empty=1.
- Fill and stall: mem_ready=0, stores 1..5 to 0x40,0x44,0x48,0x4c,0x50 -> first four accepted, full=1, count=4, cpu_stall=1 on the fifth. Raise mem_ready -> 0x40 pops, the fifth is accepted next cycle, and drain order is 0x40..0x50.
- Push+pop at count 2 -> count stays 2. Wrap across pointer boundary for 10 stores -> the memory sees all 10 in order with no loss or duplication.
- Forwarding youngest: mem_ready=0, store 7 to 0x54, then 9 to 0x54, then load 0x54 -> fwd_hit=1, fwd_data=9. Load 0x58 -> fwd_hit=0, fwd_data=0.
- Forward during pop: a single entry {0x2c, 9} with mem_ready=1 and load 0x2c in the same cycle -> fwd_hit=1, fwd_data=9. The next cycle's load of 0x2c -> fwd_hit=0.

Source files
------------

// File: rtl/mem_write_buffer.sv
// Posted-store FIFO between the core's data-memory write port and memory.
// Loads that hit a queued store get the youngest matching data forwarded combinationally.
module mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_memwrite,
    input  logic [AW-1:0]            cpu_adr,
    input  logic [DW-1:0]            cpu_writedata,
    input  logic                     cpu_memread,
    output logic                     cpu_stall,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] adr_q  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic          push, pop;
    logic [PW-1:0] idx;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign mem_we    = ~empty;
    assign mem_adr   = adr_q[head_q];
    assign mem_wdata = data_q[head_q];
    // Stall depends only on registered fullness, never on mem_ready.
    assign cpu_stall = cpu_memwrite & full;
    assign push      = cpu_memwrite & ~full;
    assign pop       = mem_we & mem_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload is deliberately left out of reset; validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            adr_q[tail_q]  <= cpu_adr;
            data_q[tail_q] <= cpu_writedata;
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (cpu_memread && (CW'(i) < count_q) && (adr_q[idx] == cpu_adr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: reset, drain, stall, wrap and forwarding scenarios.
module tb_mem_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_memwrite;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_writedata;
    logic          cpu_memread;
    logic          cpu_stall;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          empty;
    logic          full;
    logic [$clog2(DEPTH):0] count;

    int errors = 0;
    int checks = 0;

    mem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
        .cpu_memread(cpu_memread), .cpu_stall(cpu_stall),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_memwrite = 1'b0; cpu_adr = '0; cpu_writedata = '0;
        cpu_memread = 1'b0; mem_ready = 1'b0;
        #12;
        checks++; if (count !== 3'd0)    begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
        checks++; if (fwd_hit !== 1'b0)  begin errors++; $display("FAIL rst_fwd_hit got=%b exp=0", fwd_hit); end
        checks++; if (fwd_data !== 32'd0) begin errors++; $display("FAIL rst_fwd_data got=%0d exp=0", fwd_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        cpu_memwrite = 1'b1; cpu_adr = 32'h18; cpu_writedata = 32'd21; mem_ready = 1'b1;
        tick();
        cpu_memwrite = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b1)     begin errors++; $display("FAIL single_we got=%b exp=1", mem_we); end
        checks++; if (mem_adr !== 32'h18)  begin errors++; $display("FAIL single_adr got=%h exp=18", mem_adr); end
        checks++; if (mem_wdata !== 32'd21) begin errors++; $display("FAIL single_data got=%0d exp=21", mem_wdata); end
        checks++; if (count !== 3'd1)      begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        tick();
        checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL single_empty got=%b exp=1", empty); end
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL single_we_off got=%b exp=0", mem_we); end
    endtask

    task automatic test_fill_stall();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cpu_memwrite = 1'b1; cpu_adr = 32'h40 + 32'(4 * k); cpu_writedata = 32'(k + 1);
            #1;
            checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d got=%b exp=0", k, cpu_stall); end
            tick();
        end
        cpu_adr = 32'h50; cpu_writedata = 32'd5;
        #1;
        checks++; if (full !== 1'b1)      begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (count !== 3'd4)     begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL fill_stall5 got=%b exp=1", cpu_stall); end
        checks++; if (mem_adr !== 32'h40) begin errors++; $display("FAIL fill_head0 got=%h exp=40", mem_adr); end
        mem_ready = 1'b1;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL fill_stall_ready got=%b exp=1", cpu_stall); end
        tick();
        checks++; if (count !== 3'd3)     begin errors++; $display("FAIL fill_refused_count got=%0d exp=3", count); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fill_unstall got=%b exp=0", cpu_stall); end
        checks++; if (mem_adr !== 32'h44) begin errors++; $display("FAIL fill_head1 got=%h exp=44", mem_adr); end
        tick();
        cpu_memwrite = 1'b0;
        checks++; if (count !== 3'd3)     begin errors++; $display("FAIL fill_pushpop_count got=%0d exp=3", count); end
        checks++; if (mem_adr !== 32'h48) begin errors++; $display("FAIL fill_head2 got=%h exp=48", mem_adr); end
        tick();
        checks++; if (mem_adr !== 32'h4c) begin errors++; $display("FAIL fill_head3 got=%h exp=4c", mem_adr); end
        tick();
        checks++; if (mem_adr !== 32'h50 || mem_wdata !== 32'd5)
            begin errors++; $display("FAIL fill_head4 got=%h/%0d exp=50/5", mem_adr, mem_wdata); end
        tick();
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL fill_drained got=%b exp=1", empty); end
    endtask

    task automatic test_push_pop_count2();
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cpu_memwrite = 1'b1; cpu_adr = 32'h100 + 32'(4 * k); cpu_writedata = 32'(50 + k);
            tick();
        end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL pp_pre_count got=%0d exp=2", count); end
        cpu_adr = 32'h108; cpu_writedata = 32'd52; mem_ready = 1'b1;
        tick();
        cpu_memwrite = 1'b0;
        checks++; if (count !== 3'd2)      begin errors++; $display("FAIL pp_count got=%0d exp=2", count); end
        checks++; if (mem_adr !== 32'h104) begin errors++; $display("FAIL pp_head got=%h exp=104", mem_adr); end
        tick(); tick();
        checks++; if (empty !== 1'b1)      begin errors++; $display("FAIL pp_drained got=%b exp=1", empty); end
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        bit do_push, do_pop;
        while (popped < 10 && cyc < 80) begin
            cpu_memwrite  = (pushed < 10);
            cpu_adr       = 32'h200 + 32'(4 * pushed);
            cpu_writedata = 32'(100 + pushed);
            mem_ready     = (cyc % 3 != 2);
            #1;
            checks++; if (cpu_stall !== (cpu_memwrite && (pushed - popped == DEPTH)))
                begin errors++; $display("FAIL wrap_stall cyc=%0d got=%b", cyc, cpu_stall); end
            do_pop = mem_we && mem_ready;
            if (do_pop) begin
                checks++; if (mem_adr !== 32'h200 + 32'(4 * popped) || mem_wdata !== 32'(100 + popped))
                    begin errors++; $display("FAIL wrap_order got=%h/%0d exp=%h/%0d", mem_adr, mem_wdata, 32'h200 + 4 * popped, 100 + popped); end
            end
            do_push = cpu_memwrite && (pushed - popped < DEPTH);
            tick();
            if (do_push) pushed++;
            if (do_pop)  popped++;
            checks++; if (int'(count) != pushed - popped)
                begin errors++; $display("FAIL wrap_count got=%0d exp=%0d", count, pushed - popped); end
            cyc++;
        end
        cpu_memwrite = 1'b0;
        checks++; if (popped != 10) begin errors++; $display("FAIL wrap_total got=%0d exp=10", popped); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_fwd_youngest();
        mem_ready = 1'b0;
        cpu_memwrite = 1'b1; cpu_adr = 32'h54; cpu_writedata = 32'd7;
        tick();
        cpu_writedata = 32'd9;
        tick();
        cpu_memwrite = 1'b0; cpu_memread = 1'b1; cpu_adr = 32'h54;
        #1;
        checks++; if (fwd_hit !== 1'b1)   begin errors++; $display("FAIL fwd_young_hit got=%b exp=1", fwd_hit); end
        checks++; if (fwd_data !== 32'd9) begin errors++; $display("FAIL fwd_young_data got=%0d exp=9", fwd_data); end
        cpu_adr = 32'h58;
        #1;
        checks++; if (fwd_hit !== 1'b0)   begin errors++; $display("FAIL fwd_miss_hit got=%b exp=0", fwd_hit); end
        checks++; if (fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_miss_data got=%0d exp=0", fwd_data); end
        cpu_memread = 1'b0; cpu_adr = 32'h54;
        #1;
        checks++; if (fwd_hit !== 1'b0)   begin errors++; $display("FAIL fwd_noread_hit got=%b exp=0", fwd_hit); end
        mem_ready = 1'b1;
        tick(); tick();
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL fwd_drained got=%b exp=1", empty); end
    endtask

    task automatic test_fwd_pop();
        mem_ready = 1'b0;
        cpu_memwrite = 1'b1; cpu_adr = 32'h2c; cpu_writedata = 32'd9;
        tick();
        cpu_memwrite = 1'b0; cpu_memread = 1'b1; mem_ready = 1'b1;
        #1;
        checks++; if (fwd_hit !== 1'b1)   begin errors++; $display("FAIL fwdpop_hit got=%b exp=1", fwd_hit); end
        checks++; if (fwd_data !== 32'd9) begin errors++; $display("FAIL fwdpop_data got=%0d exp=9", fwd_data); end
        tick();
        checks++; if (fwd_hit !== 1'b0)   begin errors++; $display("FAIL fwdpop_after got=%b exp=0", fwd_hit); end
        cpu_memread = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cpu_memwrite = 1'b1; cpu_adr = 32'h300 + 32'(4 * k); cpu_writedata = 32'(k);
            tick();
        end
        cpu_memwrite = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmd_pre_count got=%0d exp=3", count); end
        #1 reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0)  begin errors++; $display("FAIL rmd_count got=%0d exp=0", count); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmd_we got=%b exp=0", mem_we); end
        checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL rmd_empty got=%b exp=1", empty); end
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rmd_stale_%0d got=%b exp=0", k, mem_we); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_push_pop_count2();
        test_wrap();
        test_fwd_youngest();
        test_fwd_pop();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
